// File: rtl/tone_seq_pkg.sv
// Shared types and default widths for the tone sequencer.
package tone_seq_pkg;

  localparam int unsigned TS_ACC_W   = 32;
  localparam int unsigned TS_DWELL_W = 24;
  localparam int unsigned TS_DEPTH   = 8;
  localparam int unsigned TS_IDX_W   = $clog2(TS_DEPTH);
  localparam int unsigned TS_NUM_W   = TS_IDX_W + 1;
  localparam int unsigned TS_ENTRY_W = TS_ACC_W + TS_DWELL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [TS_ACC_W-1:0]   step;
    logic [TS_DWELL_W-1:0] dwell;
  } tone_entry_t;

endpackage

// File: rtl/tone_seq_table.sv
// Tone table: DEPTH-entry register file, one write port, one registered read port.
// A same-cycle write and read of one entry returns the old contents.
module tone_seq_table
  import tone_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = TS_DEPTH,
  parameter int unsigned DATA_W = TS_ENTRY_W,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; read data reflects pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_tone_sequencer.sv
// Plays a programmed list of (step, dwell) tones into the NCO step stream.
// Optional feature macro: TONE_SEQ_RAMP_EN (ramp tdata toward each new step).
module axis_tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = TS_ACC_W,
  parameter int unsigned DEPTH       = TS_DEPTH,
  parameter int unsigned DWELL_WIDTH = TS_DWELL_W,
  parameter int unsigned RAMP_SHIFT  = 4
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     cfg_wr_addr,
  input  logic [ACC_WIDTH-1:0]         cfg_wr_step,
  input  logic [DWELL_WIDTH-1:0]       cfg_wr_dwell,
  input  logic [$clog2(DEPTH):0]       cfg_num_tones,
  input  logic                         cfg_loop,
  input  logic                         start,
  input  logic                         stop,
  output logic [ACC_WIDTH-1:0]         m_axis_step_tdata,
  output logic                         m_axis_step_tvalid,
  input  logic                         m_axis_step_tready,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH)-1:0]     tone_idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned NUM_W = IDX_W + 1;
  localparam int unsigned ENT_W = ACC_WIDTH + DWELL_WIDTH;

  if (RAMP_SHIFT >= ACC_WIDTH) begin : g_bad_ramp_shift
    $error("RAMP_SHIFT must be smaller than ACC_WIDTH");
  end

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_W-1:0]       num_q, num_d;
  logic                   loop_q, loop_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   tdata_q, tdata_d;
  logic                   tvalid_q, busy_q, done_q;
  logic [ENT_W-1:0]       rd_data;
  logic [ACC_WIDTH-1:0]   rd_step;
  logic [DWELL_WIDTH-1:0] rd_dwell;
  logic                   beat;
  logic                   last_tone;

  assign rd_step   = rd_data[ENT_W-1:DWELL_WIDTH];
  assign rd_dwell  = rd_data[DWELL_WIDTH-1:0];
  assign beat      = tvalid_q & m_axis_step_tready;
  assign last_tone = (idx_q == IDX_W'(num_q - NUM_W'(1)));

  // Read address follows the next index so the entry is ready during LOAD.
  tone_seq_table #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W),
    .ADDR_W (IDX_W)
  ) u_table (
    .clk     (aclk),
    .wr_en   (cfg_wr_en),
    .wr_addr (cfg_wr_addr),
    .wr_data ({cfg_wr_step, cfg_wr_dwell}),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

`ifdef TONE_SEQ_RAMP_EN
  logic [ACC_WIDTH-1:0] target_q, target_d;
  logic [ACC_WIDTH-1:0] ramp_diff, ramp_delta, ramp_next;
  logic                 ramp_up;

  // One ramp step toward the target: |diff|>>RAMP_SHIFT, at least 1, never past it.
  always_comb begin
    ramp_up    = (target_q > tdata_q);
    ramp_diff  = ramp_up ? (target_q - tdata_q) : (tdata_q - target_q);
    ramp_delta = ramp_diff >> RAMP_SHIFT;
    if (ramp_delta == '0) ramp_delta = ACC_WIDTH'(1);
    ramp_next  = ramp_up ? (tdata_q + ramp_delta) : (tdata_q - ramp_delta);
  end
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    tdata_d = tdata_q;
`ifdef TONE_SEQ_RAMP_EN
    target_d = target_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_num_tones != '0) begin
            state_d = LOAD;
            num_d   = cfg_num_tones;
            loop_d  = cfg_loop;
            idx_d   = '0;
          end else begin
            state_d = FIN;
          end
        end
      end
      LOAD: begin
        cnt_d = (rd_dwell == '0) ? DWELL_WIDTH'(1) : rd_dwell;
`ifdef TONE_SEQ_RAMP_EN
        target_d = rd_step;
`else
        tdata_d  = rd_step;
`endif
        state_d = RUN;
      end
      RUN: begin
        if (beat) begin
`ifdef TONE_SEQ_RAMP_EN
          if (tdata_q != target_q) tdata_d = ramp_next;
          else
`endif
          if (cnt_q == DWELL_WIDTH'(1)) begin
            cnt_d = '0;
            if (last_tone && !loop_q) begin
              state_d = FIN;
            end else begin
              idx_d   = last_tone ? '0 : (idx_q + IDX_W'(1));
              state_d = LOAD;
            end
          end else begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TONE_SEQ_RAMP_EN
      target_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      loop_q   <= loop_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= (state_d == RUN);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FIN);
`ifdef TONE_SEQ_RAMP_EN
      target_q <= target_d;
`endif
    end
  end

  assign m_axis_step_tdata  = tdata_q;
  assign m_axis_step_tvalid = tvalid_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign tone_idx           = idx_q;

endmodule
